// File: rtl/lzc_vec_builder.sv
// Rebuilds a bit vector from a stream of {cnt, empty} bit indices, one vector per packet.
// Latency: vector valid the cycle after the last beat is accepted; one idle index cycle per packet.
// Backpressure: index input stalls (ready low) while the rebuilt vector waits for vec_ready_i.
module lzc_vec_builder #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         idx_valid_i,
    output logic                         idx_ready_o,
    input  logic [CNT_WIDTH-1:0]         idx_i,
    input  logic                         idx_empty_i,
    input  logic                         idx_last_i,
    output logic                         vec_valid_o,
    input  logic                         vec_ready_i,
    output logic [WIDTH-1:0]             vec_o,
    output logic [$clog2(WIDTH+1)-1:0]   vec_cnt_o,
    output logic                         dup_o,
    output logic                         oor_o
);

    localparam int unsigned VCW = $clog2(WIDTH + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       vec_q, vec_d;
    logic [VCW-1:0]         cnt_q, cnt_d;
    logic                   dup_q, dup_d;
    logic                   oor_q, oor_d;

    logic [CNT_WIDTH-1:0]   bit_pos;
    logic [WIDTH-1:0]       bit_oh;
    logic                   in_range;
    logic                   hit;

    // MODE=1 counts from the MSB; only meaningful for in-range indices.
    assign bit_pos  = MODE ? (CNT_WIDTH'(WIDTH - 1) - idx_i) : idx_i;
    assign in_range = (32'(idx_i) < WIDTH);
    assign bit_oh   = WIDTH'(1) << bit_pos;
    assign hit      = |(vec_q & bit_oh);

    // Next-state: accumulate in ACCUM, hold in OUT until consumed; flush overrides everything.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        dup_d   = dup_q;
        oor_d   = oor_q;
        case (state_q)
            ACCUM: begin
                if (idx_valid_i) begin
                    if (!idx_empty_i) begin
                        if (!in_range) begin
                            oor_d = 1'b1;
                        end else if (hit) begin
                            dup_d = 1'b1;
                        end else begin
                            vec_d = vec_q | bit_oh;
                            cnt_d = cnt_q + VCW'(1);
                        end
                    end
                    if (idx_last_i) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (vec_ready_i) begin
                    state_d = ACCUM;
                    vec_d   = '0;
                    cnt_d   = '0;
                    dup_d   = 1'b0;
                    oor_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
        if (flush_i) begin
            state_d = ACCUM;
            vec_d   = '0;
            cnt_d   = '0;
            dup_d   = 1'b0;
            oor_d   = 1'b0;
        end
    end

    // State and accumulated vector registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
            vec_q   <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            dup_q   <= dup_d;
            oor_q   <= oor_d;
        end
    end

    assign idx_ready_o = (state_q == ACCUM);
    assign vec_valid_o = (state_q == OUT);
    assign vec_o       = vec_q;
    assign vec_cnt_o   = cnt_q;
    assign dup_o       = dup_q;
    assign oor_o       = oor_q;

`ifndef SYNTHESIS
    a_idx_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        idx_valid_i |-> !$isunknown(idx_i));
    a_vec_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (vec_valid_o && !vec_ready_i && !flush_i) |=> $stable(vec_o));
    a_cnt_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
        32'(vec_cnt_o) == 32'($countones(vec_o)));
`endif

endmodule
